operand_sequencer: RTL
======================

Name: operand_sequencer

Overview:
- Upstream stage of the 4:1 operand select mux in the CPU datapath.
- Accepts a packed group of four operands through a valid/ready handshake and registers them onto the mux data inputs a, b, c and d.
- Then steps the 2-bit mux select through all four positions, one beat per accepted output cycle, in ascending or descending order.
- Flags each beat valid and marks the final beat, so downstream logic samples the mux output once per operand.

Parameters:
- WIDTH, 4, bit width of each operand and of each mux data input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand group on in_data is valid.
- in_ready  output  1  sequencer can accept a group this cycle.
- in_data  input  4*WIDTH  packed operands: [WIDTH-1:0] goes to a, next slice to b, then c, then d in the top slice.
- in_desc  input  1  order for this group: 0 = ascending (sel 0,1,2,3), 1 = descending (sel 3,2,1,0). Sampled only at accept.
- a, b, c, d  output  WIDTH each  registered operands driving the mux data inputs.
- sel  output  2  mux select.
- out_valid  output  1  current sel/a..d beat is valid.
- out_last  output  1  current beat is the fourth of the group.
- out_ready  input  1  downstream consumed the current beat.

Behaviour:
- Reset, synchronous and active-high: clk and reset are the only clock and reset; reset takes priority over all other inputs.
  - state = IDLE.
  - a, b, c, d = 0; sel = 2'b00.
  - out_valid = 0; out_last = 0; beat count = 0.
- Accept: a group is accepted when in_valid && in_ready at a rising edge.
  - On accept, register a..d from in_data and latch in_desc.
  - sel is set to 0 (ascending) or 3 (descending); beat count is cleared.
  - State goes to SCAN.
  - Latency: out_valid rises the cycle after accept, with the first sel already valid.
- IDLE:
  - in_ready = 1; out_valid = 0; out_last = 0.
  - a..d and sel hold their last values.
- SCAN:
  - out_valid = 1.
  - out_last = 1 exactly when beat count = 3.
  - A beat completes on out_valid && out_ready.
  - On a beat that is not the last, sel moves by +1 (ascending) or -1 (descending) and beat count increments.
  - out_ready = 0 stalls the scan: sel, a..d, out_last and beat count all hold.
- in_ready is 1 in IDLE, or in SCAN in the same cycle the last beat completes (out_last && out_ready). It is 0 otherwise.
- Last beat completes with no accept: go to IDLE. out_valid = 0 next cycle.
- Last beat completes and a new group is accepted in the same cycle: stay in SCAN and load the new group. out_valid stays 1 with no bubble; the first beat of the new group appears the next cycle.
- sel never wraps inside a group: exactly four beats per group, each select position visited exactly once.
- Changes to in_data or in_desc while in_ready = 0 are ignored.
- Reset mid-scan abandons the group. Outputs return to reset values on the next edge and no partial-group state survives.
- Arithmetic: sel and beat count are 2-bit modular. Completion is decided by beat count, never by the sel value.

Decomposition:
- Shared package holds:
  - state encoding IDLE = 1'b0, SCAN = 1'b1;
  - NUM_OPERANDS = 4;
  - SEL_W = 2;
  - localparams SEL_FIRST_ASC = 2'd0 and SEL_FIRST_DESC = 2'd3.
- One natural sub-module: sel_stepper. It is a 2-bit loadable up/down counter with enable, producing sel, beat count and last.
- The operand registers and the handshake FSM stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with in_valid = 1 -> a..d = 0, sel = 0, out_valid = 0, out_last = 0, in_ready = 1 in the cycle after reset deasserts.
- Ascending: in_data = 16'hDCBA, in_desc = 0, out_ready = 1 -> a = A, b = B, c = C, d = D. Over the next 4 cycles sel = 0,1,2,3, out_last only on sel = 3, then out_valid = 0.
- Descending with stall: in_data = 16'h4321, in_desc = 1, out_ready low on the second beat for 3 cycles -> sel = 3,2,2,2,2,1,0. Beat count and out_last hold during the stall.
- Back-to-back: second group 16'h8765 presented with in_valid held during the first group's last beat -> in_ready = 1 only in that cycle. out_valid stays continuously high; sel goes 3 then 0 with a = 5.
- Ignored input: change in_data mid-scan while in_valid = 1 -> a..d unchanged until the group completes; new data is accepted only on the last beat.
- Mid-scan reset: assert reset at sel = 2 -> next cycle out_valid = 0, sel = 0, a..d = 0. A following fresh group scans all four beats.

Source files
------------

// File: rtl/operand_sequencer_pkg.sv
// Shared types and constants for the operand sequencer and its select stepper.
package operand_sequencer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

  localparam int unsigned NUM_OPERANDS = 4;
  localparam int unsigned SEL_W        = 2;

  localparam logic [SEL_W-1:0] SEL_FIRST_ASC  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_FIRST_DESC = 2'd3;
  localparam logic [SEL_W-1:0] LAST_BEAT      = SEL_W'(NUM_OPERANDS - 1);

endpackage

// File: rtl/operand_sequencer_sel_stepper.sv
// Loadable 2-bit up/down select counter with a beat counter that decides group completion.
module operand_sequencer_sel_stepper
  import operand_sequencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             desc_i,
  input  logic             step_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [SEL_W-1:0] count_o,
  output logic             last_o
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] count_q, count_d;
  logic             desc_q, desc_d;

  always_comb begin
    sel_d   = sel_q;
    count_d = count_q;
    desc_d  = desc_q;
    if (load_i) begin
      desc_d  = desc_i;
      sel_d   = desc_i ? SEL_FIRST_DESC : SEL_FIRST_ASC;
      count_d = '0;
    end else if (step_i) begin
      sel_d   = desc_q ? SEL_W'(sel_q - 2'd1) : SEL_W'(sel_q + 2'd1);
      count_d = SEL_W'(count_q + 2'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q   <= SEL_FIRST_ASC;
      count_q <= '0;
      desc_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      count_q <= count_d;
      desc_q  <= desc_d;
    end
  end

  assign sel_o   = sel_q;
  assign count_o = count_q;
  assign last_o  = (count_q == LAST_BEAT);

endmodule

// File: rtl/operand_sequencer.sv
// Registers a packed group of four operands onto the mux inputs and scans the mux select
// across all four positions, one beat per downstream handshake.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic                 in_desc,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     d,
  output logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [SEL_W-1:0] beat_cnt;
  logic             stepper_last;
  logic             accept;
  logic             beat_done;
  logic             step;

  always_comb begin
    out_valid = (state_q == StScan);
    out_last  = out_valid && stepper_last;
    // A new group may slot in behind the final beat so the scan runs without a bubble.
    in_ready  = (state_q == StIdle) || (out_last && out_ready);
    accept    = in_valid && in_ready;
    beat_done = out_valid && out_ready;
    step      = beat_done && (beat_cnt != LAST_BEAT);

    state_d = state_q;
    if (accept) begin
      state_d = StScan;
    end else if (beat_done && out_last) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= in_data[0*WIDTH +: WIDTH];
        b_q <= in_data[1*WIDTH +: WIDTH];
        c_q <= in_data[2*WIDTH +: WIDTH];
        d_q <= in_data[3*WIDTH +: WIDTH];
      end
    end
  end

  operand_sequencer_sel_stepper u_sel_stepper (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (accept),
    .desc_i  (in_desc),
    .step_i  (step),
    .sel_o   (sel),
    .count_o (beat_cnt),
    .last_o  (stepper_last)
  );

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;

endmodule
